gpx2_echo_select: RTL

Parametrised GPX2 TDC result processor, the multi-echo successor to the two-stop GPX2 result controller. It sits downstream of the GPX2 LVDS deserialiser and upstream of the distance/packet logic. On a read request it latches one start stamp and ECHO_NUM rise/fall stop-stamp pairs, and converts each raw stamp (reference index plus stop offset) to a linear time relative to start. It qualifies each echo, selects one echo by a run-time mode, and then presents the selected {rise, fall} pair with a one-cycle valid strobe.

---
 rtl/gpx2_echo_select.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gpx2_echo_select.sv
// gpx2_echo_select
//   Multi-echo GPX2 result processor. A read request latches one start stamp
//   and ECHO_NUM rise/fall stamp pairs. The block converts each stamp to a
//   linear time relative to start, qualifies each echo, and selects one echo
//   by mode. It then presents the selected {rise, fall} pair with a one-cycle
//   strobe.
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   i_gpx2_rdresult      read request (sampled in IDLE only)
//   i_sel_mode           0 first valid, 1 widest, 2 last valid, 3 as 0
//   i_result_start       raw start stamp
//   i_result_rise/fall   raw stop stamps, echo k at slice k
//   o_gpx2_result        {rise, fall} of the selected echo
//   o_gpx2_signal        one-cycle result-valid strobe
//   o_hit/o_echo_idx/o_echo_cnt  selection summary
//   o_busy               high outside IDLE
module gpx2_echo_select #(
    parameter int ECHO_NUM = 2,
    parameter int REF_DIV  = 40000,
    parameter int REFIDX_W = 8,
    parameter int STOP_W   = 16,
    parameter int TIME_W   = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_gpx2_rdresult,
    input  logic [1:0]                   i_sel_mode,
    input  logic [TIME_W-1:0]            i_result_start,
    input  logic [ECHO_NUM*TIME_W-1:0]   i_result_rise,
    input  logic [ECHO_NUM*TIME_W-1:0]   i_result_fall,
    output logic [2*TIME_W-1:0]          o_gpx2_result,
    output logic                         o_gpx2_signal,
    output logic                         o_hit,
    output logic [2:0]                   o_echo_idx,
    output logic [3:0]                   o_echo_cnt,
    output logic                         o_busy
);

    localparam int            IW     = (ECHO_NUM > 1) ? $clog2(ECHO_NUM) : 1;
    localparam logic [IW-1:0] K_LAST = IW'(ECHO_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CONVERT, S_SELECT, S_OUTPUT} state_t;

    state_t                            state_q;
    logic [1:0]                        mode_q;
    logic [TIME_W-1:0]                 start_q;
    logic [ECHO_NUM-1:0][TIME_W-1:0]   rise_q, fall_q;
    logic [ECHO_NUM-1:0][TIME_W-1:0]   trise_q, tfall_q;
    logic [ECHO_NUM-1:0]               ev_q;
    logic [IW-1:0]                     k_q, sel_q;
    logic                              found_q;
    logic [TIME_W-1:0]                 best_q;
    logic [3:0]                        cnt_q;

    // Linear stop-counter time of a raw word, truncated to TIME_W.
    function automatic logic [TIME_W-1:0] lin(input logic [TIME_W-1:0] w);
        return TIME_W'(w[STOP_W +: REFIDX_W]) * TIME_W'(REF_DIV) + TIME_W'(w[STOP_W-1:0]);
    endfunction

    // Conversion of echo k_q (CONVERT) and selection decision (SELECT).
    logic [TIME_W-1:0] cr, cf, st_lin, tr_c, tf_c, w_c;
    logic              rv, fv, ev_c, take_c;

    always_comb begin
        cr     = rise_q[k_q];
        cf     = fall_q[k_q];
        st_lin = lin(start_q);
        // All-ones marks an empty stop slot; a stamp not after start is bogus.
        rv     = (cr != '1) && (cr > start_q);
        fv     = (cf != '1) && (cf > start_q);
        tr_c   = rv ? lin(cr) - st_lin : '0;
        tf_c   = fv ? lin(cf) - st_lin : '0;
        ev_c   = rv && fv && (tf_c > tr_c);

        w_c    = tfall_q[k_q] - trise_q[k_q];
        case (mode_q)
            2'd1:    take_c = ev_q[k_q] && (!found_q || (w_c > best_q)); // ties keep lower index
            2'd2:    take_c = ev_q[k_q];
            default: take_c = ev_q[k_q] && !found_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            start_q       <= '0;
            rise_q        <= '0;
            fall_q        <= '0;
            trise_q       <= '0;
            tfall_q       <= '0;
            ev_q          <= '0;
            k_q           <= '0;
            sel_q         <= '0;
            found_q       <= 1'b0;
            best_q        <= '0;
            cnt_q         <= '0;
            o_gpx2_result <= '0;
            o_gpx2_signal <= 1'b0;
            o_hit         <= 1'b0;
            o_echo_idx    <= '0;
            o_echo_cnt    <= '0;
            o_busy        <= 1'b0;
        end else begin
            o_gpx2_signal <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_gpx2_rdresult) begin
                        state_q <= S_LATCH;
                        o_busy  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    start_q <= i_result_start;
                    rise_q  <= i_result_rise;
                    fall_q  <= i_result_fall;
                    mode_q  <= i_sel_mode;
                    ev_q    <= '0;
                    k_q     <= '0;
                    sel_q   <= '0;
                    found_q <= 1'b0;
                    best_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= S_CONVERT;
                end
                S_CONVERT: begin
                    trise_q[k_q] <= tr_c;
                    tfall_q[k_q] <= tf_c;
                    ev_q[k_q]    <= ev_c;
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= S_SELECT;
                    end else begin
                        k_q <= k_q + IW'(1);
                    end
                end
                S_SELECT: begin
                    if (ev_q[k_q]) cnt_q <= cnt_q + 4'd1;
                    if (take_c) begin
                        found_q <= 1'b1;
                        sel_q   <= k_q;
                        best_q  <= w_c;
                    end
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= S_OUTPUT;
                    end else begin
                        k_q <= k_q + IW'(1);
                    end
                end
                S_OUTPUT: begin
                    o_gpx2_signal <= 1'b1;
                    o_busy        <= 1'b0;
                    state_q       <= S_IDLE;
                    if (found_q) begin
                        o_gpx2_result <= {trise_q[sel_q], tfall_q[sel_q]};
                        o_echo_idx    <= 3'(sel_q);
                        o_echo_cnt    <= cnt_q;
                        o_hit         <= 1'b1;
                    end else begin
                        o_gpx2_result <= '0;
                        o_echo_idx    <= '0;
                        o_echo_cnt    <= '0;
                        o_hit         <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
